// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter.
// The winner's byte is latched and presented on tx_datain, a fixed-width
// tx_wrsig strobe starts the frame, and the transmitter's busy flag is tracked
// until the frame ends (or never starts, which triggers a timeout abort).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SYNC      | after reset: wait for a frame left running in the UART
// IDLE      | no owner; pick next requester round-robin
// STROBE    | tx_wrsig high for STROBE_CYC cycles
// WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE | frame on the line; wait for tx_busy to fall (no timeout)
// GAP       | enforced idle time between frames; grant released
module uart_tx_arbiter #(
   parameter int STROBE_CYC   = 4,
   parameter int BUSY_TIMEOUT = 4096,
   parameter int GAP_CYC      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] data_in,
   output logic [3:0]  grant,
   output logic [3:0]  ack,
   output logic        err_timeout,
   output logic [7:0]  tx_datain,
   output logic        tx_wrsig,
   input  logic        tx_busy
);

   // Counter widths: strobe/gap counters hold (count-1), timeout holds BUSY_TIMEOUT.
   localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [SW-1:0] STRB_LOAD = SW'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
   localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [TW-1:0] TMO_LOAD  = TW'(BUSY_TIMEOUT);

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      STROBE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } state_t;

   state_t        state, state_n;
   logic [3:0]    grant_n, ack_n;
   logic          err_n, wrsig_n;
   logic [7:0]    datain_n;
   logic [1:0]    last_grant, last_grant_n;
   logic [SW-1:0] strb_cnt, strb_cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic [TW-1:0] tmo_cnt, tmo_cnt_n;
   logic [TW-1:0] tmo_dec;

   logic          rr_found;
   logic [1:0]    rr_pick;
   logic [1:0]    rr_idx;

   // Round-robin search starting one past the previous owner, wrapping at 4.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = last_grant;
      rr_idx   = last_grant;
      for (int i = 1; i <= 4; i++) begin
         rr_idx = last_grant + 2'(i);
         if (!rr_found && req[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx;
         end
      end
   end

   // Timeout is a saturating down-counter so it can never wrap past zero.
   assign tmo_dec = (tmo_cnt != '0) ? tmo_cnt - TW'(1) : '0;

   // Next-state and next-output logic for every registered signal.
   always_comb begin
      state_n      = state;
      grant_n      = grant;
      ack_n        = '0;
      err_n        = 1'b0;
      datain_n     = tx_datain;
      last_grant_n = last_grant;
      strb_cnt_n   = strb_cnt;
      gap_cnt_n    = gap_cnt;
      tmo_cnt_n    = tmo_cnt;

      case (state)
         SYNC: begin
            grant_n = '0;
            if (!tx_busy) state_n = IDLE;
         end
         IDLE: begin
            if (rr_found) begin
               grant_n      = 4'b0001 << rr_pick;
               datain_n     = data_in[{rr_pick, 3'b000} +: 8];
               last_grant_n = rr_pick;
               strb_cnt_n   = STRB_LOAD;
               tmo_cnt_n    = TMO_LOAD;
               state_n      = STROBE;
            end
         end
         STROBE: begin
            tmo_cnt_n = tmo_dec;
            if (strb_cnt == '0) state_n = WAIT_BUSY;
            else                strb_cnt_n = strb_cnt - SW'(1);
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               tmo_cnt_n = '0;
               state_n   = WAIT_DONE;
            end else if (tmo_cnt <= TW'(1)) begin
               // Terminal count: the UART never acknowledged the strobe.
               ack_n     = grant;
               err_n     = 1'b1;
               tmo_cnt_n = '0;
               gap_cnt_n = GAP_LOAD;
               state_n   = GAP;
            end else begin
               tmo_cnt_n = tmo_dec;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               ack_n     = grant;
               gap_cnt_n = GAP_LOAD;
               state_n   = GAP;
            end
         end
         GAP: begin
            // grant stays visible through the ack cycle and drops here.
            grant_n = '0;
            if (gap_cnt == '0) state_n = IDLE;
            else               gap_cnt_n = gap_cnt - GW'(1);
         end
         default: begin
            grant_n = '0;
            state_n = SYNC;
         end
      endcase

      wrsig_n = (state_n == STROBE);
   end

   // State and output registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SYNC;
         grant       <= '0;
         ack         <= '0;
         err_timeout <= 1'b0;
         tx_datain   <= 8'h00;
         tx_wrsig    <= 1'b0;
         last_grant  <= 2'd3;
         strb_cnt    <= '0;
         gap_cnt     <= '0;
         tmo_cnt     <= '0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         ack         <= ack_n;
         err_timeout <= err_n;
         tx_datain   <= datain_n;
         tx_wrsig    <= wrsig_n;
         last_grant  <= last_grant_n;
         strb_cnt    <= strb_cnt_n;
         gap_cnt     <= gap_cnt_n;
         tmo_cnt     <= tmo_cnt_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural UART transmitter model.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic        err_timeout;
   logic [7:0]  tx_datain;
   logic        tx_wrsig;
   logic        tx_busy;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(.STROBE_CYC(4), .BUSY_TIMEOUT(4096), .GAP_CYC(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data_in     (data_in),
      .grant       (grant),
      .ack         (ack),
      .err_timeout (err_timeout),
      .tx_datain   (tx_datain),
      .tx_wrsig    (tx_wrsig),
      .tx_busy     (tx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // UART model: captures the byte on each tx_wrsig rise and stays busy
   // for FRAME cycles; tie_low models a transmitter that never responds.
   localparam int FRAME = 20;
   logic [7:0] line_q[$];
   int   busy_left = 0;
   int   wr_rises  = 0;
   logic prev_wr   = 1'b0;
   bit   tie_low   = 1'b0;

   initial tx_busy = 1'b0;

   always @(posedge clk) begin
      #2;
      if (tx_wrsig === 1'b1 && prev_wr === 1'b0) begin
         wr_rises = wr_rises + 1;
         if (!tie_low) begin
            line_q.push_back(tx_datain);
            busy_left = FRAME;
         end
      end
      prev_wr = tx_wrsig;
      if (busy_left > 0) begin
         tx_busy   = 1'b1;
         busy_left = busy_left - 1;
      end else begin
         tx_busy = 1'b0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_grant(output bit ok, output int zeros);
      ok = 1'b0;
      zeros = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (grant != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         zeros++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One complete frame: grant, strobe width, ack, byte on the line.
   task automatic do_frame(input string nm, input logic [3:0] rq, input logic [31:0] dat,
                           input logic [3:0] eg, input logic [7:0] eb, input bit keep,
                           input bit chg, input logic [31:0] chg_dat, input bit drop_mid,
                           output int zeros, output int tail);
      bit ok;
      int hi, post, rises0;
      logic [7:0] got;
      req    = rq;
      data_in = dat;
      rises0 = wr_rises;
      wait_grant(ok, zeros);
      check({nm, "_granted"}, 32'(ok), 32'd1);
      check({nm, "_grant"}, 32'(grant), 32'(eg));
      check({nm, "_datain"}, 32'(tx_datain), 32'(eb));
      if (chg) data_in = chg_dat;
      hi = 0;
      post = 0;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (ack != 4'b0000) begin
            ok = 1'b1;
            break;
         end
         if (tx_wrsig) hi++;
         else          post++;
         if (drop_mid && post == 3) req = 4'b0000;
         @(negedge clk);
      end
      check({nm, "_ack_seen"}, 32'(ok), 32'd1);
      check({nm, "_ack"}, 32'(ack), 32'(eg));
      check({nm, "_err"}, 32'(err_timeout), 32'd0);
      check({nm, "_wrsig_cycles"}, 32'(hi), 32'd4);
      check({nm, "_datain_held"}, 32'(tx_datain), 32'(eb));
      check({nm, "_wr_rises"}, 32'(wr_rises - rises0), 32'd1);
      if (line_q.size() > 0) got = line_q.pop_front();
      else                   got = 8'hxx;
      check({nm, "_line"}, 32'(got), 32'(eb));
      if (!keep) req = 4'b0000;
      @(negedge clk);
      check({nm, "_ack_pulse"}, 32'(ack), 32'd0);
      check({nm, "_grant_release"}, 32'(grant), 32'd0);
      tail = (grant == 4'b0000) ? 1 : 0;
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  exp_grant;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t tbl[8];

   initial begin
      bit ok;
      bit bad;
      int z, t, prev_t, n;
      logic [7:0] got;
      logic [7:0] cont_b[4];

      // Round-robin pointer after reset is 3; each row follows the previous one.
      tbl[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5};
      tbl[1] = '{4'b1011, 32'h4433_2211, 4'b1000, 8'h44};
      tbl[2] = '{4'b1011, 32'h8877_6655, 4'b0001, 8'h55};
      tbl[3] = '{4'b0110, 32'hCCBB_AA99, 4'b0010, 8'hAA};
      tbl[4] = '{4'b0001, 32'h0000_005A, 4'b0001, 8'h5A};
      tbl[5] = '{4'b1000, 32'hE100_0000, 4'b1000, 8'hE1};
      tbl[6] = '{4'b0101, 32'h00C3_00F0, 4'b0001, 8'hF0};
      tbl[7] = '{4'b1100, 32'h7E69_0000, 4'b0100, 8'h69};
      cont_b[0] = 8'h11; cont_b[1] = 8'h22; cont_b[2] = 8'h33; cont_b[3] = 8'h44;

      // Reset with every request asserted: reset must win.
      rst = 1'b1;
      req = 4'b1111;
      data_in = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_wrsig", 32'(tx_wrsig), 32'd0);
      check("rst_datain", 32'(tx_datain), 32'h00);
      req = 4'b0000;
      rst = 1'b0;
      @(negedge clk);

      // Contention: all four held, order 0,1,2,3,0.
      prev_t = 0;
      for (int f = 0; f < 5; f++) begin
         do_frame("cont", 4'b1111, 32'h4433_2211, 4'(4'b0001 << (f % 4)), cont_b[f % 4],
                  (f < 4), 1'b0, 32'h0, 1'b0, z, t);
         if (f > 0) check("cont_gap", 32'((prev_t + z) >= 2), 32'd1);
         prev_t = t;
      end

      do_reset();
      for (int v = 0; v < 8; v++)
         do_frame("tbl", tbl[v].req, tbl[v].data, tbl[v].exp_grant, tbl[v].exp_byte,
                  1'b0, 1'b0, 32'h0, 1'b0, z, t);

      // Byte changes after grant: the latched byte must be sent.
      do_frame("datachg", 4'b0010, 32'h0000_3C00, 4'b0010, 8'h3C,
               1'b0, 1'b1, 32'h0000_FF00, 1'b0, z, t);

      // Requester 3 drops its request mid-frame.
      do_frame("drop", 4'b1000, 32'h5D00_0000, 4'b1000, 8'h5D,
               1'b0, 1'b0, 32'h0, 1'b1, z, t);
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (grant != 4'b0000 || ack != 4'b0000) bad = 1'b1;
      end
      check("drop_no_regrant", 32'(bad), 32'd0);

      // Reset during WAIT_DONE, transmitter keeps sending its frame.
      req = 4'b0010;
      data_in = 32'h0000_6600;
      wait_grant(ok, z);
      check("rstmid_granted", 32'(ok), 32'd1);
      check("rstmid_grant", 32'(grant), 32'b0010);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!tx_wrsig) break;
      end
      if (line_q.size() > 0) got = line_q.pop_front();
      else                   got = 8'hxx;
      check("rstmid_line", 32'(got), 32'h66);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0011;
      @(negedge clk);
      check("rstmid_wrsig", 32'(tx_wrsig), 32'd0);
      check("rstmid_grant0", 32'(grant), 32'd0);
      check("rstmid_ack0", 32'(ack), 32'd0);
      check("rstmid_busy_still", 32'(tx_busy), 32'd1);
      rst = 1'b0;
      bad = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (grant != 4'b0000 || ack != 4'b0000) bad = 1'b1;
         if (!tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("rstmid_busy_fell", 32'(ok), 32'd1);
      check("rstmid_hold_off", 32'(bad), 32'd0);
      do_frame("rstmid_rr", 4'b0011, 32'h0000_6677, 4'b0001, 8'h77,
               1'b0, 1'b0, 32'h0, 1'b0, z, t);

      // Timeout: transmitter never raises busy.
      tie_low = 1'b1;
      req = 4'b0001;
      data_in = 32'h0000_00C7;
      wait_grant(ok, z);
      check("tmo_granted", 32'(ok), 32'd1);
      check("tmo_grant", 32'(grant), 32'b0001);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         n++;
         if (ack != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
      check("tmo_seen", 32'(ok), 32'd1);
      check("tmo_cycles", 32'(n), 32'd4096);
      check("tmo_ack", 32'(ack), 32'b0001);
      check("tmo_err", 32'(err_timeout), 32'd1);
      req = 4'b0000;
      @(negedge clk);
      check("tmo_err_pulse", 32'(err_timeout), 32'd0);
      check("tmo_ack_pulse", 32'(ack), 32'd0);
      check("tmo_grant_clr", 32'(grant), 32'd0);
      check("tmo_wrsig_gap", 32'(tx_wrsig), 32'd0);
      tie_low = 1'b0;
      do_frame("post_tmo", 4'b0100, 32'h00E4_0000, 4'b0100, 8'hE4,
               1'b0, 1'b0, 32'h0, 1'b0, z, t);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
